// File: rtl/button_pkg.sv
// Shared definitions for the push-button event decoder: state encoding and
// default timing constants.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } btn_state_t;

  localparam int LONG_DELAY_DEF    = 50_000_000;
  localparam int DCLICK_WINDOW_DEF = 12_500_000;
  localparam int EVT_W             = 8;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, event pulses / hold level / event count out.
interface button_event_decoder_if;
  import button_pkg::*;

  logic             d_i;
  logic             click_o;
  logic             dclick_o;
  logic             long_o;
  logic             held_o;
  logic [EVT_W-1:0] evt_cnt_o;

  modport master (
    output d_i,
    input  click_o, dclick_o, long_o, held_o, evt_cnt_o
  );

  modport slave (
    input  d_i,
    output click_o, dclick_o, long_o, held_o, evt_cnt_o
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into single click, double click and
// long press events using one FSM and one shared, never-wrapping counter.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_DELAY    = LONG_DELAY_DEF,
  parameter int DCLICK_WINDOW = DCLICK_WINDOW_DEF,
  parameter int CNT_W         = 31
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  button_event_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_DELAY - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             click_q;
  logic             dclick_q;
  logic             long_q;
  logic             held_q;
  logic [EVT_W-1:0] evt_q;

  // Counter is cleared on every state entry and compared before increment,
  // so it never needs to wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_i) begin
            state <= PRESS;
            cnt   <= '0;
          end
        end
        PRESS: begin
          if (bus.d_i) begin
            if (cnt == LONG_LAST) begin
              state  <= LONG;
              long_q <= 1'b1;
              held_q <= 1'b1;
              evt_q  <= evt_q + EVT_W'(1);
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state <= GAP;
            cnt   <= '0;
          end
        end
        LONG: begin
          if (!bus.d_i) begin
            state  <= IDLE;
            held_q <= 1'b0;
          end
        end
        GAP: begin
          // A press on the expiry edge still counts as a double click.
          if (bus.d_i) begin
            state    <= PRESS2;
            dclick_q <= 1'b1;
            evt_q    <= evt_q + EVT_W'(1);
          end else if (cnt == DCLICK_LAST) begin
            state   <= IDLE;
            click_q <= 1'b1;
            evt_q   <= evt_q + EVT_W'(1);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESS2: begin
          if (!bus.d_i) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.click_o   = click_q;
  assign bus.dclick_o  = dclick_q;
  assign bus.long_o    = long_q;
  assign bus.held_o    = held_q;
  assign bus.evt_cnt_o = evt_q;

endmodule
